skin_mask_stats: RTL and testbench
==================================

// Module: skin_mask_stats
// PURPOSE
//  Consumes the HSV pixel stream from the colour-space stage and thresholds each pixel against runtime H/S/V windows.
//  Emits a 1-bit skin mask with re-timed syncs, and accumulates per-frame skin statistics (count, sum x, sum y).
//  Statistics are latched on each frame boundary for the downstream tracker.
// PARAMETERS
//  X_W    11  width of column counter (max 2047 px per line)
//  Y_W    11  width of line counter (max 2047 lines)
//  CNT_W  22  width of skin-pixel counter; saturates at all-ones
// PORTS
//  clk          in   1        pixel clock
//  rst          in   1        asynchronous reset, active-high
//  ce           in   1        clock enable; all state holds when low
//  de_in        in   1        data enable, aligned with H/S/V
//  hsync_in     in   1        horizontal sync, aligned with H/S/V
//  vsync_in     in   1        vertical sync, aligned with H/S/V; rising edge = frame start
//  H,S,V        in   8 each   pixel in HSV, 0..255 scale
//  h_min,h_max  in   8 each   hue window; wraps when h_min > h_max
//  s_min,s_max  in   8 each   saturation window, inclusive
//  v_min        in   8        minimum value, inclusive
//  mask         out  1        skin flag, 1 cycle latency
//  de_out,hsync_out,vsync_out  out  1 each  inputs delayed 1 ce-cycle
//  frame_valid  out  1        1-cycle pulse when the stats outputs update
//  pix_count    out  CNT_W    skin pixels in the last completed frame
//  sum_x        out  X_W+CNT_W   sum of column indices of skin pixels
//  sum_y        out  Y_W+CNT_W   sum of line indices of skin pixels
// BEHAVIOUR
//  Reset: every output and internal register is 0, except the bbox min registers, which reset to all-ones.
//  Pixel qualification:
//   hue_ok = (h_min<=h_max) ? (h_min<=H<=h_max) : (H>=h_min || H<=h_max).
//   Pixel is skin when de_in && hue_ok && s_min<=S<=s_max && V>=v_min.
//   mask is registered: latency exactly 1 ce-cycle, and mask=0 whenever de_in=0.
//  Counters:
//   x counts de_in-high cycles within a line and clears on de_in falling.
//   y increments on de_in falling and clears on vsync_in rising.
//   Pixel index = current x,y before increment; first pixel of a frame is (0,0).
//  Accumulation, on a skin pixel:
//   pix_count_acc += 1, saturating; when saturated, the sums also stop updating.
//   sum_x_acc += x; sum_y_acc += y. Widths never overflow below saturation.
//  Frame boundary (vsync_in rising, detected with a registered vsync):
//   Copy the accumulators to the outputs, pulse frame_valid for 1 cycle, then clear the accumulators.
//   Simultaneous event: if a skin pixel coincides with the vsync rise, it counts into the NEW frame.
//   The latched values exclude that pixel.
//  ce=0: counters, accumulators, edge detector, and the delay line all freeze; frame_valid cannot pulse.
//  Reset mid-frame: statistics for the partial frame are discarded; the first frame_valid comes after the next vsync rise.
// CONFIGURATION
//  SKIN_BBOX_EN defined:
//   Adds outputs bbox_x_min, bbox_x_max (X_W) and bbox_y_min, bbox_y_max (Y_W), tracked per skin pixel.
//   They are latched and cleared together with the stats.
//   For an empty frame the outputs are min=all-ones and max=0.
//  SKIN_BBOX_EN undefined: the bbox ports and registers do not exist; all other behaviour is identical.
// STRUCTURE
//  skin_pkg: threshold field widths (8), default window constants (H 0..25, S 40..170, V>=60), and the bbox empty value.
//  Sub-module hsv_window_cmp: combinational window compare, including hue wrap; instantiated once.
// TESTING
//  1. Reset asserted mid-line -> all outputs 0 within the same cycle; no frame_valid until after the next vsync rise.
//  2. h_min=0,h_max=25,s 40..170,v_min=60; input HSV (10,100,200) -> mask=1 one cycle later.
//     Input (10,30,200) -> mask=0.
//  3. Hue wrap: h_min=240,h_max=10; H=250 -> 1, H=5 -> 1, H=128 -> 0 (S/V in range).
//  4. 4x2 frame, skin at (1,0),(3,0),(2,1), then vsync rise -> frame_valid pulse with pix_count=3, sum_x=6, sum_y=1.
//     With SKIN_BBOX_EN: bbox=(1,3,0,1).
//  5. Skin pixel coincident with vsync rise -> latched stats exclude it; the next frame's pix_count includes it (=1 if alone).
//  6. ce toggled 1/0 every cycle over test 4 -> identical results; the delay outputs advance only on ce=1.

Source files
------------

// File: rtl/skin_pkg.sv
// Shared constants for the skin-mask stage: threshold field width, default HSV window
// and the empty-bbox marker used when SKIN_BBOX_EN is defined.
package skin_pkg;

  localparam int THR_W = 8;

  localparam logic [THR_W-1:0] DEF_H_MIN = 8'd0;
  localparam logic [THR_W-1:0] DEF_H_MAX = 8'd25;
  localparam logic [THR_W-1:0] DEF_S_MIN = 8'd40;
  localparam logic [THR_W-1:0] DEF_S_MAX = 8'd170;
  localparam logic [THR_W-1:0] DEF_V_MIN = 8'd60;

  // Wide enough for any coordinate width; slice to size at the use site.
  localparam logic [15:0] BBOX_EMPTY = 16'hffff;

endpackage

// File: rtl/hsv_window_cmp.sv
// Combinational HSV window test; the hue window wraps through 255/0 when h_min > h_max.
module hsv_window_cmp
  import skin_pkg::*;
(
  input  logic [THR_W-1:0] h,
  input  logic [THR_W-1:0] s,
  input  logic [THR_W-1:0] v,
  input  logic [THR_W-1:0] h_min,
  input  logic [THR_W-1:0] h_max,
  input  logic [THR_W-1:0] s_min,
  input  logic [THR_W-1:0] s_max,
  input  logic [THR_W-1:0] v_min,
  output logic             hit
);

  logic hue_ok;

  always_comb begin
    if (h_min <= h_max) hue_ok = (h >= h_min) && (h <= h_max);
    else                hue_ok = (h >= h_min) || (h <= h_max);
    hit = hue_ok && (s >= s_min) && (s <= s_max) && (v >= v_min);
  end

endmodule

// File: rtl/skin_mask_stats.sv
// HSV skin thresholding with registered mask/syncs and per-frame count/sum_x/sum_y statistics.
// Optional SKIN_BBOX_EN adds a per-frame bounding box of skin pixels.
module skin_mask_stats
  import skin_pkg::*;
#(
  parameter int X_W   = 11,
  parameter int Y_W   = 11,
  parameter int CNT_W = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 de_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [THR_W-1:0]     H,
  input  logic [THR_W-1:0]     S,
  input  logic [THR_W-1:0]     V,
  input  logic [THR_W-1:0]     h_min,
  input  logic [THR_W-1:0]     h_max,
  input  logic [THR_W-1:0]     s_min,
  input  logic [THR_W-1:0]     s_max,
  input  logic [THR_W-1:0]     v_min,
  output logic                 mask,
  output logic                 de_out,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 frame_valid,
  output logic [CNT_W-1:0]     pix_count,
  output logic [X_W+CNT_W-1:0] sum_x,
  output logic [Y_W+CNT_W-1:0] sum_y
`ifdef SKIN_BBOX_EN
  ,
  output logic [X_W-1:0]       bbox_x_min,
  output logic [X_W-1:0]       bbox_x_max,
  output logic [Y_W-1:0]       bbox_y_min,
  output logic [Y_W-1:0]       bbox_y_max
`endif
);

  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;

  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [CNT_W-1:0] cnt_acc, cnt_n;
  logic [SX_W-1:0]  sx_acc, sx_n;
  logic [SY_W-1:0]  sy_acc, sy_n;
  logic             win, skin, vs_rise;

`ifdef SKIN_BBOX_EN
  localparam logic [X_W-1:0] X_EMPTY = BBOX_EMPTY[X_W-1:0];
  localparam logic [Y_W-1:0] Y_EMPTY = BBOX_EMPTY[Y_W-1:0];
  logic [X_W-1:0] bx0_acc, bx1_acc, bx0_n, bx1_n;
  logic [Y_W-1:0] by0_acc, by1_acc, by0_n, by1_n;
`endif

  hsv_window_cmp u_cmp (
    .h     (H),
    .s     (S),
    .v     (V),
    .h_min (h_min),
    .h_max (h_max),
    .s_min (s_min),
    .s_max (s_max),
    .v_min (v_min),
    .hit   (win)
  );

  // vsync_out/de_out double as the registered copies used for edge detection.
  assign skin    = de_in && win;
  assign vs_rise = vsync_in && !vsync_out;

  // On a frame boundary the accumulators restart from empty, so a coincident skin pixel lands in the new frame.
  always_comb begin
    cnt_n = vs_rise ? '0 : cnt_acc;
    sx_n  = vs_rise ? '0 : sx_acc;
    sy_n  = vs_rise ? '0 : sy_acc;
    if (skin && !(&cnt_n)) begin
      cnt_n = cnt_n + CNT_W'(1);
      sx_n  = sx_n + SX_W'(x);
      sy_n  = sy_n + SY_W'(y);
    end
`ifdef SKIN_BBOX_EN
    bx0_n = vs_rise ? X_EMPTY : bx0_acc;
    bx1_n = vs_rise ? '0      : bx1_acc;
    by0_n = vs_rise ? Y_EMPTY : by0_acc;
    by1_n = vs_rise ? '0      : by1_acc;
    if (skin) begin
      if (x < bx0_n) bx0_n = x;
      if (x > bx1_n) bx1_n = x;
      if (y < by0_n) by0_n = y;
      if (y > by1_n) by1_n = y;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask        <= 1'b0;
      de_out      <= 1'b0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      frame_valid <= 1'b0;
      pix_count   <= '0;
      sum_x       <= '0;
      sum_y       <= '0;
      x           <= '0;
      y           <= '0;
      cnt_acc     <= '0;
      sx_acc      <= '0;
      sy_acc      <= '0;
`ifdef SKIN_BBOX_EN
      bx0_acc     <= X_EMPTY;
      bx1_acc     <= '0;
      by0_acc     <= Y_EMPTY;
      by1_acc     <= '0;
      bbox_x_min  <= X_EMPTY;
      bbox_x_max  <= '0;
      bbox_y_min  <= Y_EMPTY;
      bbox_y_max  <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      if (ce) begin
        mask      <= skin;
        de_out    <= de_in;
        hsync_out <= hsync_in;
        vsync_out <= vsync_in;
        x         <= de_in ? x + X_W'(1) : '0;
        if (vs_rise)               y <= '0;
        else if (de_out && !de_in) y <= y + Y_W'(1);
        cnt_acc   <= cnt_n;
        sx_acc    <= sx_n;
        sy_acc    <= sy_n;
`ifdef SKIN_BBOX_EN
        bx0_acc   <= bx0_n;
        bx1_acc   <= bx1_n;
        by0_acc   <= by0_n;
        by1_acc   <= by1_n;
`endif
        if (vs_rise) begin
          frame_valid <= 1'b1;
          pix_count   <= cnt_acc;
          sum_x       <= sx_acc;
          sum_y       <= sy_acc;
`ifdef SKIN_BBOX_EN
          bbox_x_min  <= bx0_acc;
          bbox_x_max  <= bx1_acc;
          bbox_y_min  <= by0_acc;
          bbox_y_max  <= by1_acc;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_skin_mask_stats.sv
// Scoreboard bench for skin_mask_stats: stimulus pushes expected pixel/frame results from a
// behavioural model; an independent monitor pops and compares when the DUT presents outputs.
module tb_skin_mask_stats;
  import skin_pkg::*;

  localparam int X_W = 11, Y_W = 11, CNT_W = 22;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, ce, de_in, hsync_in, vsync_in;
  logic [7:0] H, S, V, h_min, h_max, s_min, s_max, v_min;
  logic mask, de_out, hsync_out, vsync_out, frame_valid;
  logic [CNT_W-1:0] pix_count;
  logic [X_W+CNT_W-1:0] sum_x;
  logic [Y_W+CNT_W-1:0] sum_y;
`ifdef SKIN_BBOX_EN
  logic [X_W-1:0] bbox_x_min, bbox_x_max;
  logic [Y_W-1:0] bbox_y_min, bbox_y_max;
`endif

  skin_mask_stats #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .H(H), .S(S), .V(V), .h_min(h_min), .h_max(h_max), .s_min(s_min), .s_max(s_max), .v_min(v_min),
    .mask(mask), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_valid(frame_valid), .pix_count(pix_count), .sum_x(sum_x), .sum_y(sum_y)
`ifdef SKIN_BBOX_EN
    , .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max), .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {longint cnt, sx, sy, bx0, bx1, by0, by1;} stats_t;
  typedef struct {bit m, de, hs, vs;} pix_t;

  stats_t stats_q[$];
  pix_t   pix_q[$];
  int total = 0, bad = 0;
  bit ce_tog = 0;

  // reference model state: position within the frame, previous sync levels, running frame totals
  int m_x, m_y;
  bit m_de, m_vs;
  stats_t acc;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_skin(input bit de, input int h, input int s, input int v);
    bit hue;
    if (h_min <= h_max) hue = (h >= h_min) && (h <= h_max);
    else                hue = !((h > h_max) && (h < h_min));
    return de && hue && s >= s_min && s <= s_max && v >= v_min;
  endfunction

  function automatic stats_t empty_stats();
    stats_t e;
    e.cnt = 0; e.sx = 0; e.sy = 0;
    e.bx0 = (1 << X_W) - 1; e.bx1 = 0;
    e.by0 = (1 << Y_W) - 1; e.by1 = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_de = 0; m_vs = 0;
    acc = empty_stats();
  endtask

  task automatic model_step(input bit de, input bit hs, input bit vs, input int h, input int s, input int v);
    pix_t p;
    bit sk;
    bit rise;
    sk = is_skin(de, h, s, v);
    rise = vs && !m_vs;
    if (rise) begin
      stats_q.push_back(acc);
      acc = empty_stats();
    end
    if (sk) begin
      if (acc.cnt < CNT_MAX) begin
        acc.cnt++; acc.sx += m_x; acc.sy += m_y;
      end
      if (m_x < acc.bx0) acc.bx0 = m_x;
      if (m_x > acc.bx1) acc.bx1 = m_x;
      if (m_y < acc.by0) acc.by0 = m_y;
      if (m_y > acc.by1) acc.by1 = m_y;
    end
    p.m = sk; p.de = de; p.hs = hs; p.vs = vs;
    pix_q.push_back(p);
    if (rise) m_y = 0;
    else if (m_de && !de) m_y = m_y + 1;
    m_x = de ? (m_x + 1) % (1 << X_W) : 0;
    m_de = de; m_vs = vs;
  endtask

  // one clock: drive at negedge, return just after the following posedge
  task automatic cyc(input bit c, input bit de, input bit hs, input bit vs, input int h, input int s, input int v);
    @(negedge clk);
    ce = c; de_in = de; hsync_in = hs; vsync_in = vs;
    H = 8'(h); S = 8'(s); V = 8'(v);
    if (c) model_step(de, hs, vs, h, s, v);
    @(posedge clk);
    #1;
  endtask

  // one logical pixel; in toggle mode a ce=0 cycle of junk precedes it
  task automatic px(input bit de, input bit hs, input bit vs, input int h, input int s, input int v);
    if (ce_tog) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255));
    cyc(1, de, hs, vs, h, s, v);
  endtask

  task automatic idle(input int n, input bit vs);
    for (int i = 0; i < n; i++) px(0, 0, vs, 0, 0, 0);
  endtask

  task automatic vs_pulse();
    idle(2, 0);
    idle(2, 1);
    idle(2, 0);
  endtask

  function automatic bit directed_skin(input int x, input int y);
    return (x == 1 && y == 0) || (x == 3 && y == 0) || (x == 2 && y == 1);
  endfunction

  task automatic frame(input int w, input int h, input bit rnd);
    vs_pulse();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (rnd) px(1, 0, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        else if (directed_skin(x, y)) px(1, 0, 0, 10, 100, 200);
        else px(1, 0, 0, 10, 30, 200);
      end
      px(0, 1, 0, 0, 0, 0);
      px(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic set_default_window();
    h_min = DEF_H_MIN; h_max = DEF_H_MAX; s_min = DEF_S_MIN; s_max = DEF_S_MAX; v_min = DEF_V_MIN;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; ce = 0; de_in = 0; hsync_in = 0; vsync_in = 0;
    #1;
    check("rst_mask", mask, 0);
    check("rst_de_out", de_out, 0);
    check("rst_hsync_out", hsync_out, 0);
    check("rst_vsync_out", vsync_out, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_pix_count", pix_count, 0);
    check("rst_sum_x", sum_x, 0);
    check("rst_sum_y", sum_y, 0);
`ifdef SKIN_BBOX_EN
    check("rst_bbox_x_min", bbox_x_min, (1 << X_W) - 1);
    check("rst_bbox_y_max", bbox_y_max, 0);
`endif
    check("rst_pending_pix", pix_q.size(), 0);
    pix_q.delete();
    stats_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  // monitor: compare at posedge+1 against whatever the stimulus side queued
  pix_t last;
  initial begin
    bit ce_e, rst_e;
    pix_t p;
    stats_t e;
    last = '{0, 0, 0, 0};
    forever begin
      @(posedge clk);
      ce_e = ce; rst_e = rst;
      #1;
      if (rst_e || rst) begin
        last = '{0, 0, 0, 0};
      end else if (ce_e) begin
        if (pix_q.size() == 0) check("pix_queue_underflow", 1, 0);
        else begin
          p = pix_q.pop_front();
          check("mask", mask, p.m);
          check("de_out", de_out, p.de);
          check("hsync_out", hsync_out, p.hs);
          check("vsync_out", vsync_out, p.vs);
          last = p;
        end
        if (frame_valid) begin
          if (stats_q.size() == 0) check("frame_valid_unexpected", 1, 0);
          else begin
            e = stats_q.pop_front();
            check("pix_count", pix_count, e.cnt);
            check("sum_x", sum_x, e.sx);
            check("sum_y", sum_y, e.sy);
`ifdef SKIN_BBOX_EN
            check("bbox_x_min", bbox_x_min, e.bx0);
            check("bbox_x_max", bbox_x_max, e.bx1);
            check("bbox_y_min", bbox_y_min, e.by0);
            check("bbox_y_max", bbox_y_max, e.by1);
`endif
          end
        end
        if (stats_q.size() != 0) check("frame_valid_missing", 0, 1);
      end else begin
        check("hold_mask", mask, last.m);
        check("hold_de_out", de_out, last.de);
        check("hold_vsync_out", vsync_out, last.vs);
        check("frame_valid_on_ce_low", frame_valid, 0);
      end
    end
  end

  initial begin
    rst = 1; ce = 0; de_in = 0; hsync_in = 0; vsync_in = 0; H = 0; S = 0; V = 0;
    set_default_window();
    model_reset();
    do_reset();

    // basic window and saturation-edge pixels
    px(1, 0, 0, 10, 100, 200);
    px(1, 0, 0, 10, 30, 200);
    px(1, 0, 0, 25, 170, 60);
    px(1, 0, 0, 26, 100, 200);
    px(1, 0, 0, 10, 100, 59);
    px(0, 0, 0, 10, 100, 200);
    h_min = 240; h_max = 10;
    px(1, 0, 0, 250, 100, 200);
    px(1, 0, 0, 5, 100, 200);
    px(1, 0, 0, 128, 100, 200);
    px(0, 0, 0, 0, 0, 0);
    set_default_window();

    // reset mid-line with skin already accumulated: partial frame must vanish
    px(1, 0, 0, 10, 100, 200);
    px(1, 0, 0, 10, 100, 200);
    do_reset();
    idle(3, 0);

    // 4x2 directed frame, latched by the next frame's vsync rise
    frame(4, 2, 0);
    // skin pixel coincident with the vsync rise: latched stats exclude it, next frame holds only it
    px(1, 0, 1, 10, 100, 200);
    idle(2, 1);
    idle(3, 0);
    vs_pulse();

    // same directed frame with ce alternating every cycle
    ce_tog = 1;
    frame(4, 2, 0);
    vs_pulse();
    ce_tog = 0;

    // random windows and frames
    for (int f = 0; f < 8; f++) begin
      h_min = 8'($urandom_range(0, 255));
      h_max = 8'($urandom_range(0, 255));
      s_min = 8'($urandom_range(0, 100));
      s_max = 8'($urandom_range(120, 255));
      v_min = 8'($urandom_range(0, 128));
      ce_tog = (f % 3 == 2);
      frame($urandom_range(3, 12), $urandom_range(2, 6), 1);
    end
    ce_tog = 0;
    vs_pulse();
    idle(4, 0);

    check("end_pix_queue_empty", pix_q.size(), 0);
    check("end_stats_queue_empty", stats_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
